// File: rtl/phaser_in_tap_ctrl_if.sv
// Command handshake between the memory-calibration logic and the phaser tap sequencer.
// The master issues one command at a time and gets back a completion pulse plus the current fine tap.
interface phaser_in_tap_ctrl_if;
  logic       REQVALID;
  logic       REQREADY;
  logic [1:0] REQOP;
  logic [5:0] REQVAL;
  logic       DONE;
  logic       ERR;
  logic [5:0] CURTAP;

  modport master (
    output REQVALID, REQOP, REQVAL,
    input  REQREADY, DONE, ERR, CURTAP
  );

  modport slave (
    input  REQVALID, REQOP, REQVAL,
    output REQREADY, DONE, ERR, CURTAP
  );
endinterface

// File: rtl/phaser_in_tap_ctrl.sv
// SYSCLK-domain sequencer for the X_PHASER_IN_PHY control pins: paced fine-tap stepping,
// coarse counter load and DQS-find restart, one command at a time with DONE/ERR reporting.
module phaser_in_tap_ctrl #(
  parameter int INIT_TAP      = 0,
  parameter int SETTLE_CYCLES = 8,
  parameter int FIND_TIMEOUT  = 1024
) (
  input  logic                 SYSCLK,
  input  logic                 RST,
  phaser_in_tap_ctrl_if.slave  req,
  input  logic                 PHASELOCKED,
  input  logic                 FINEOVERFLOW,
  input  logic                 DQSFOUND,
  output logic                 FINEENABLE,
  output logic                 FINEINC,
  output logic                 COUNTERLOADEN,
  output logic [5:0]           COUNTERLOADVAL,
  output logic                 RSTDQSFIND
);

  typedef enum logic [2:0] {IDLE, STEP, SETTLE, LOAD, FIND_RST, FIND_WAIT, FIN} state_t;
  typedef enum logic [1:0] {OP_MOVE, OP_LOAD, OP_FIND, OP_RSVD} op_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST   = 16'(FIND_TIMEOUT - 1);
  localparam logic [5:0]  TAP_RESET   = 6'(INIT_TAP);

  state_t      state;
  op_t         op;
  logic [5:0]  target;
  logic [5:0]  curtap;
  logic [15:0] cnt;
  logic        ready;
  logic        done;
  logic        err;
  logic        accept;

  // NOTE: ready is a registered "sitting in IDLE" flag; the lock qualifier is
  // combinational so a lost lock blocks acceptance in the very same cycle.
  assign req.REQREADY = ready & PHASELOCKED;
  assign accept       = req.REQVALID & ready & PHASELOCKED;
  assign req.DONE     = done;
  assign req.ERR      = err;
  assign req.CURTAP   = curtap;

  // NOTE: all state and outputs use non-blocking assignments so every branch
  // sees the values from before the edge, exactly like the flops they become.
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state          <= IDLE;
      op             <= OP_MOVE;
      target         <= '0;
      curtap         <= TAP_RESET;
      cnt            <= '0;
      ready          <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      FINEENABLE     <= 1'b0;
      FINEINC        <= 1'b0;
      COUNTERLOADEN  <= 1'b0;
      COUNTERLOADVAL <= '0;
      RSTDQSFIND     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          ready <= 1'b1;
          if (accept) begin
            ready  <= 1'b0;
            op     <= op_t'(req.REQOP);
            target <= req.REQVAL;
            cnt    <= '0;
            case (op_t'(req.REQOP))
              OP_MOVE: begin
                if (req.REQVAL == curtap) begin
                  state <= FIN;
                  done  <= 1'b1;
                end else begin
                  state      <= STEP;
                  FINEENABLE <= 1'b1;
                  FINEINC    <= (req.REQVAL > curtap);
                end
              end
              OP_LOAD: begin
                state          <= LOAD;
                COUNTERLOADEN  <= 1'b1;
                COUNTERLOADVAL <= req.REQVAL;
              end
              OP_FIND: begin
                state      <= FIND_RST;
                RSTDQSFIND <= 1'b1;
              end
              default: begin
                state <= FIN;
                done  <= 1'b1;
                err   <= 1'b1;
              end
            endcase
          end
        end

        // The pulse always finishes and the tap always moves, even if lock was lost.
        STEP: begin
          FINEENABLE <= 1'b0;
          curtap     <= FINEINC ? curtap + 6'd1 : curtap - 6'd1;
          cnt        <= '0;
          if (!PHASELOCKED) begin
            state <= FIN;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            state <= SETTLE;
          end
        end

        LOAD: begin
          COUNTERLOADEN <= 1'b0;
          cnt           <= '0;
          if (!PHASELOCKED) begin
            state <= FIN;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            state <= SETTLE;
          end
        end

        SETTLE: begin
          if (FINEOVERFLOW || !PHASELOCKED) begin
            state <= FIN;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (cnt == SETTLE_LAST) begin
            if (op == OP_LOAD || curtap == target) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state      <= STEP;
              FINEENABLE <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        FIND_RST: begin
          if (!PHASELOCKED) begin
            RSTDQSFIND <= 1'b0;
            state      <= FIN;
            done       <= 1'b1;
            err        <= 1'b1;
          end else if (cnt == 16'd1) begin
            RSTDQSFIND <= 1'b0;
            cnt        <= '0;
            state      <= FIND_WAIT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        FIND_WAIT: begin
          if (!PHASELOCKED || (!DQSFOUND && cnt == WAIT_LAST)) begin
            state <= FIN;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (DQSFOUND) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        FIN: begin
          state <= IDLE;
          ready <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
